// File: rtl/lock_pkg.sv
// ============================================================================
// Module  : lock_pkg
// Purpose : Shared types and constants for the keypad-to-RAM lock sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lock_pkg;

    localparam int DIGIT_W = 4;
    localparam int RAM_AW  = 10;
    localparam int RAM_DW  = 32;

    localparam logic [3:0]         BE_ALL    = 4'hF;
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_CMP  = 3'd2,
        S_WR      = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lock_key_buf.sv
// ============================================================================
// Module  : lock_key_buf
// Purpose : Digit shift buffer with count, range filter and clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_key_buf
    import lock_pkg::*;
#(
    parameter int N_DIGITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               key_en,
    input  logic [DIGIT_W-1:0] key_digit,
    output logic [RAM_DW-1:0]  code,
    output logic [3:0]         digit_cnt
);

    localparam logic [3:0] c_n_digits = 4'(N_DIGITS);

    logic [RAM_DW-1:0] r_buf;
    logic [3:0]        r_cnt;
    logic              w_accept;

    // Out-of-range digits and digits past the code length are dropped.
    assign w_accept = key_en && (key_digit <= MAX_DIGIT) && (r_cnt < c_n_digits);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_buf <= {r_buf[RAM_DW-DIGIT_W-1:0], key_digit};
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign code      = r_buf;
    assign digit_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/lock_ram_ctrl.sv
// ============================================================================
// Module  : lock_ram_ctrl
// Purpose : Collects keypad digits and verifies/stores code words in RAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_ram_ctrl
    import lock_pkg::*;
#(
    parameter int                N_DIGITS       = 8,
    parameter logic [RAM_AW-1:0] SLOT_BASE      = 10'h000,
    parameter int                MAX_FAIL       = 3,
    parameter int                LOCKOUT_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               key_clear,
    input  logic               cmd_verify,
    input  logic               cmd_store,
    input  logic [3:0]         slot,
    output logic               busy,
    output logic               unlock,
    output logic               ok_pulse,
    output logic               fail_pulse,
    output logic               locked_out,
    output logic [3:0]         digit_cnt,
    output logic [RAM_AW-1:0]  ram_address,
    output logic [3:0]         ram_byteenable,
    output logic               ram_chipselect,
    output logic               ram_clken,
    output logic               ram_write,
    output logic [RAM_DW-1:0]  ram_writedata,
    input  logic [RAM_DW-1:0]  ram_readdata
);

    localparam logic [3:0]  c_n_digits  = 4'(N_DIGITS);
    localparam logic [7:0]  c_max_fail  = 8'(MAX_FAIL);
    localparam logic [31:0] c_lock_last = 32'(LOCKOUT_CYCLES - 1);

    state_t            r_state, w_state_n;
    logic              r_unlock, w_unlock_n;
    logic              r_ok, w_ok_n;
    logic              r_fail, w_fail_n;
    logic [7:0]        r_fail_cnt, w_fail_cnt_n;
    logic [31:0]       r_lock_cnt, w_lock_cnt_n;
    logic [RAM_AW-1:0] r_addr, w_addr_n;
    logic [RAM_DW-1:0] r_wdata, w_wdata_n;
    logic              r_cs, w_cs_n;
    logic              r_wr, w_wr_n;
    logic [3:0]        r_be;

    logic              w_buf_clr;
    logic              w_key_en;
    logic              w_fail_hit;
    logic              w_full;
    logic [7:0]        w_fail_inc;
    logic [RAM_AW-1:0] w_slot_addr;
    logic [RAM_DW-1:0] w_code;

    lock_key_buf #(
        .N_DIGITS (N_DIGITS)
    ) u_key_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_buf_clr),
        .key_en    (w_key_en),
        .key_digit (key_digit),
        .code      (w_code),
        .digit_cnt (digit_cnt)
    );

    assign w_full      = (digit_cnt == c_n_digits);
    assign w_fail_inc  = r_fail_cnt + 8'd1;
    assign w_slot_addr = SLOT_BASE + {{(RAM_AW-4){1'b0}}, slot};

    always_comb begin
        w_state_n    = r_state;
        w_unlock_n   = r_unlock;
        w_fail_cnt_n = r_fail_cnt;
        w_lock_cnt_n = r_lock_cnt;
        w_addr_n     = r_addr;
        w_wdata_n    = r_wdata;
        w_cs_n       = 1'b0;
        w_wr_n       = 1'b0;
        w_ok_n       = 1'b0;
        w_fail_n     = 1'b0;
        w_buf_clr    = 1'b0;
        w_key_en     = 1'b0;
        w_fail_hit   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (key_clear) begin
                    w_buf_clr  = 1'b1;
                    w_unlock_n = 1'b0;
                end else if (cmd_verify) begin
                    if (!w_full) begin
                        w_buf_clr  = 1'b1;
                        w_fail_hit = 1'b1;
                    end else begin
                        w_state_n = S_RD_ADDR;
                        w_cs_n    = 1'b1;
                        w_addr_n  = w_slot_addr;
                    end
                end else if (cmd_store) begin
                    if (r_unlock && w_full) begin
                        w_state_n = S_WR;
                        w_cs_n    = 1'b1;
                        w_wr_n    = 1'b1;
                        w_addr_n  = w_slot_addr;
                        w_wdata_n = w_code;
                    end
                end else begin
                    w_key_en = key_valid;
                end
            end
            S_RD_ADDR: w_state_n = S_RD_CMP;
            S_RD_CMP: begin
                w_buf_clr = 1'b1;
                w_state_n = S_IDLE;
                if (ram_readdata == w_code) begin
                    w_ok_n       = 1'b1;
                    w_unlock_n   = 1'b1;
                    w_fail_cnt_n = '0;
                end else begin
                    w_fail_hit = 1'b1;
                end
            end
            S_WR: begin
                w_buf_clr  = 1'b1;
                w_ok_n     = 1'b1;
                w_unlock_n = 1'b0;
                w_state_n  = S_IDLE;
            end
            S_LOCKOUT: begin
                if (r_lock_cnt == 32'd0) begin
                    w_state_n    = S_IDLE;
                    w_fail_cnt_n = '0;
                end else begin
                    w_lock_cnt_n = r_lock_cnt - 32'd1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        // Short verifies and mismatches share the failure bookkeeping.
        if (w_fail_hit) begin
            w_fail_n     = 1'b1;
            w_unlock_n   = 1'b0;
            w_fail_cnt_n = w_fail_inc;
            if (w_fail_inc >= c_max_fail) begin
                w_state_n    = S_LOCKOUT;
                w_lock_cnt_n = c_lock_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_unlock   <= 1'b0;
            r_ok       <= 1'b0;
            r_fail     <= 1'b0;
            r_fail_cnt <= '0;
            r_lock_cnt <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cs       <= 1'b0;
            r_wr       <= 1'b0;
            r_be       <= '0;
        end else begin
            r_state    <= w_state_n;
            r_unlock   <= w_unlock_n;
            r_ok       <= w_ok_n;
            r_fail     <= w_fail_n;
            r_fail_cnt <= w_fail_cnt_n;
            r_lock_cnt <= w_lock_cnt_n;
            r_addr     <= w_addr_n;
            r_wdata    <= w_wdata_n;
            r_cs       <= w_cs_n;
            r_wr       <= w_wr_n;
            r_be       <= w_cs_n ? BE_ALL : 4'h0;
        end
    end

    assign busy           = (r_state == S_RD_ADDR) || (r_state == S_RD_CMP) || (r_state == S_WR);
    assign locked_out     = (r_state == S_LOCKOUT);
    assign unlock         = r_unlock;
    assign ok_pulse       = r_ok;
    assign fail_pulse     = r_fail;
    assign ram_address    = r_addr;
    assign ram_byteenable = r_be;
    assign ram_chipselect = r_cs;
    assign ram_clken      = 1'b1;
    assign ram_write      = r_wr;
    assign ram_writedata  = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_lock_ram_ctrl.sv
// ============================================================================
// Module  : tb_lock_ram_ctrl
// Purpose : Self-checking bench for lock_ram_ctrl with a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lock_ram_ctrl;

    localparam int N  = 8;
    localparam int MF = 3;
    localparam int LC = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0, key_clear = 1'b0, cmd_verify = 1'b0, cmd_store = 1'b0;
    logic [3:0]  key_digit = 4'd0, slot = 4'd0;
    logic        busy, unlock, ok_pulse, fail_pulse, locked_out;
    logic [3:0]  digit_cnt, ram_byteenable;
    logic [9:0]  ram_address;
    logic        ram_chipselect, ram_clken, ram_write;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata = 32'd0;

    always #5 clk = ~clk;

    lock_ram_ctrl #(
        .N_DIGITS       (N),
        .SLOT_BASE      (10'h000),
        .MAX_FAIL       (MF),
        .LOCKOUT_CYCLES (LC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .key_valid      (key_valid),
        .key_digit      (key_digit),
        .key_clear      (key_clear),
        .cmd_verify     (cmd_verify),
        .cmd_store      (cmd_store),
        .slot           (slot),
        .busy           (busy),
        .unlock         (unlock),
        .ok_pulse       (ok_pulse),
        .fail_pulse     (fail_pulse),
        .locked_out     (locked_out),
        .digit_cnt      (digit_cnt),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_clken      (ram_clken),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_readdata   (ram_readdata)
    );

    // RAM slave: 1-cycle read latency, byte-enabled writes, preload port.
    logic [31:0] ram_mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = 10'd0;
    logic [31:0] pre_data = 32'd0;

    always @(posedge clk) begin
        if (pre_we) begin
            ram_mem[pre_addr] <= pre_data;
        end else if (ram_chipselect && ram_clken) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_readdata <= ram_mem[ram_address];
            end
        end
    end

    typedef struct packed {
        logic        busy, unlock, ok, fail, locked, cs, wr;
        logic [3:0]  cnt;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] m_buf, m_wdata;
    logic [9:0]  m_addr;
    int          m_cnt, m_fail;
    logic        m_unlock;

    int checks = 0, errors = 0, cyc = 0;
    logic        s_busy, s_unlock, s_ok, s_fail, s_locked, s_cs, s_wr, s_clken;
    logic [3:0]  s_cnt, s_be;
    logic [9:0]  s_addr;
    logic [31:0] s_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic bz, input logic ok, input logic fl,
                                input logic lk, input logic cs, input logic wr);
        exp_t e;
        e.busy = bz; e.ok = ok; e.fail = fl; e.locked = lk; e.cs = cs; e.wr = wr;
        e.unlock = m_unlock; e.cnt = 4'(m_cnt); e.addr = m_addr; e.wdata = m_wdata;
        return e;
    endfunction

    function automatic exp_t idle_e();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic fail_end();
        m_unlock = 1'b0;
        m_fail++;
        if (m_fail >= MF) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
            repeat (LC - 1) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
            m_fail = 0;
            exp_q.push_back(idle_e());
        end else begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        end
    endtask

    // Schedules every future cycle's outputs for one accepted request.
    task automatic model_accept(input logic kv, input logic [3:0] kd, input logic kc,
                                input logic cv, input logic cst, input logic [3:0] sl);
        logic match;
        if (kc) begin
            m_buf = 0; m_cnt = 0; m_unlock = 1'b0;
            exp_q.push_back(idle_e());
        end else if (cv) begin
            if (m_cnt != N) begin
                m_buf = 0; m_cnt = 0;
                fail_end();
            end else begin
                m_addr = 10'(sl);
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                match = (ref_mem[m_addr] == m_buf);
                m_buf = 0; m_cnt = 0;
                if (match) begin
                    m_unlock = 1'b1; m_fail = 0;
                    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
                end else begin
                    fail_end();
                end
            end
        end else if (cst) begin
            if (m_unlock && m_cnt == N) begin
                m_addr = 10'(sl); m_wdata = m_buf; ref_mem[m_addr] = m_buf;
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
                m_buf = 0; m_cnt = 0; m_unlock = 1'b0;
                exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
            end else begin
                exp_q.push_back(idle_e());
            end
        end else begin
            if (kv && kd <= 4'd9 && m_cnt < N) begin
                m_buf = (m_buf << 4) | {28'd0, kd};
                m_cnt++;
            end
            exp_q.push_back(idle_e());
        end
    endtask

    task automatic step(input logic rs, input logic kv, input logic [3:0] kd, input logic kc,
                        input logic cv, input logic cst, input logic [3:0] sl);
        exp_t e;
        @(negedge clk);
        cyc++;
        s_busy = busy; s_unlock = unlock; s_ok = ok_pulse; s_fail = fail_pulse;
        s_locked = locked_out; s_cs = ram_chipselect; s_wr = ram_write; s_clken = ram_clken;
        s_cnt = digit_cnt; s_be = ram_byteenable; s_addr = ram_address; s_wdata = ram_writedata;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy", 32'(s_busy), 32'(e.busy));
            chk("unlock", 32'(s_unlock), 32'(e.unlock));
            chk("ok_pulse", 32'(s_ok), 32'(e.ok));
            chk("fail_pulse", 32'(s_fail), 32'(e.fail));
            chk("locked_out", 32'(s_locked), 32'(e.locked));
            chk("digit_cnt", 32'(s_cnt), 32'(e.cnt));
            chk("chipselect", 32'(s_cs), 32'(e.cs));
            chk("write", 32'(s_wr), 32'(e.wr));
            chk("clken", 32'(s_clken), 32'd1);
            if (e.cs) begin
                chk("address", 32'(s_addr), 32'(e.addr));
                chk("byteenable", 32'(s_be), 32'hF);
                if (e.wr) chk("writedata", s_wdata, e.wdata);
            end
        end
        reset = rs; key_valid = kv; key_digit = kd; key_clear = kc;
        cmd_verify = cv; cmd_store = cst; slot = sl;
        if (rs) begin
            exp_q.delete();
            m_buf = 0; m_cnt = 0; m_unlock = 1'b0; m_fail = 0; m_addr = 0; m_wdata = 0;
            exp_q.push_back(idle_e());
        end else if (exp_q.size() == 0) begin
            model_accept(kv, kd, kc, cv, cst, sl);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask
    task automatic keys(input logic [31:0] w, input int nd);
        for (int i = 0; i < nd; i++) step(1'b0, 1'b1, w[31-4*i -: 4], 1'b0, 1'b0, 1'b0, 4'd0);
    endtask
    task automatic verify(input logic [3:0] sl);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, sl);
    endtask
    task automatic store(input logic [3:0] sl);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, sl);
    endtask
    task automatic junk();
        step(1'b0, 1'($urandom), 4'($urandom), ($urandom % 16) == 0,
             ($urandom % 6) == 0, ($urandom % 6) == 0, 4'($urandom));
    endtask

    function automatic logic [31:0] dword();
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < 8; i++) w = {w[27:0], 4'($urandom_range(0, 9))};
        return w;
    endfunction

    initial begin
        logic [31:0] w;
        logic [39:0] seqw;
        logic [3:0]  s;
        int          n;

        for (int a = 0; a < 1024; a++) begin
            w = (a < 16) ? dword() : $urandom;
            if (a == 2 || a == 3) w = 32'h12345678;
            ref_mem[a] = w;
            @(negedge clk);
            pre_we = 1'b1; pre_addr = 10'(a); pre_data = w;
        end
        @(negedge clk);
        pre_we = 1'b0;
        m_buf = 0; m_cnt = 0; m_unlock = 1'b0; m_fail = 0; m_addr = 0; m_wdata = 0;
        exp_q.push_back(idle_e());

        idle(1);
        chk("rst_address", 32'(s_addr), 32'd0);
        chk("rst_writedata", s_wdata, 32'd0);
        chk("rst_byteenable", 32'(s_be), 32'd0);

        // Correct verify of slot 2.
        keys(32'h12345678, 8); verify(4'd2);
        idle(1);
        chk("v_cs", 32'(s_cs), 32'd1); chk("v_addr", 32'(s_addr), 32'd2); chk("v_wr", 32'(s_wr), 32'd0);
        idle(2);
        chk("v_ok", 32'(s_ok), 32'd1); chk("v_unlock", 32'(s_unlock), 32'd1); chk("v_cnt", 32'(s_cnt), 32'd0);

        // Store a new code, then the old one must fail.
        keys(32'h87654321, 8); store(4'd2);
        idle(1);
        chk("st_wr", 32'(s_wr), 32'd1); chk("st_data", s_wdata, 32'h87654321); chk("st_be", 32'(s_be), 32'hF);
        idle(1);
        chk("st_ok", 32'(s_ok), 32'd1); chk("st_unlock", 32'(s_unlock), 32'd0);
        chk("st_ram", ram_mem[2], 32'h87654321);
        keys(32'h12345678, 8); verify(4'd2); idle(3);
        chk("old_fail", 32'(s_fail), 32'd1);

        // Three wrong verifies lead to a 20-cycle lockout.
        keys(32'h87654321, 8); verify(4'd2); idle(3);
        for (int k = 0; k < 3; k++) begin
            keys(32'h11111111, 8); verify(4'd2); idle(3);
        end
        chk("lock_fail", 32'(s_fail), 32'd1); chk("lock_enter", 32'(s_locked), 32'd1);
        n = 1;
        repeat (LC - 1) begin
            junk();
            if (s_locked) n++;
        end
        idle(1);
        chk("lock_len", n, LC); chk("lock_exit", 32'(s_locked), 32'd0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        idle(4);
        for (int k = 0; k < 2; k++) begin
            keys(32'h11111111, 8); verify(4'd2); idle(3);
        end
        chk("no_relock", 32'(s_locked), 32'd0);
        keys(32'h87654321, 8); verify(4'd2); idle(3);

        // Short verify: immediate fail, no RAM access.
        keys(32'h12345678, 5); verify(4'd2);
        idle(1);
        chk("short_fail", 32'(s_fail), 32'd1); chk("short_cs1", 32'(s_cs), 32'd0);
        idle(1);
        chk("short_cs2", 32'(s_cs), 32'd0);
        keys(32'h87654321, 8); verify(4'd2); idle(3);

        // Ten keys including an out-of-range digit.
        seqw = 40'h1234B56789;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, seqw[39-4*i -: 4], 1'b0, 1'b0, 1'b0, 4'd0);
        idle(1);
        chk("ten_cnt", 32'(s_cnt), 32'd8);
        verify(4'd3); idle(3);
        chk("ten_ok", 32'(s_ok), 32'd1);

        // Verify and store together, then reset during the compare cycle.
        keys(32'h12345678, 8);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3);
        idle(1);
        chk("both_cs", 32'(s_cs), 32'd1); chk("both_wr", 32'(s_wr), 32'd0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        idle(1);
        chk("rst_ok", 32'(s_ok), 32'd0); chk("rst_fail", 32'(s_fail), 32'd0);
        chk("rst_cs", 32'(s_cs), 32'd0); chk("rst_unlock", 32'(s_unlock), 32'd0);
        idle(2);

        // Randomized episodes checked against the model every cycle.
        for (int ep = 0; ep < 300; ep++) begin
            s = 4'($urandom);
            case ($urandom % 5)
                0: begin keys(ref_mem[10'(s)], 8); verify(s); idle(3); end
                1: begin keys(dword(), 8); store(s); idle(2); end
                2: repeat (12) junk();
                3: begin keys(dword(), int'($urandom % 10)); verify(s); idle(3); end
                default: begin step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0); idle(1); end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
